mouse_transmitter: RTL and testbench

//  Host-to-device PS/2 byte transmitter; the send-side counterpart of the mouse byte receiver.

---
 rtl/mouse_ps2_pkg.sv | 37 +++
 rtl/mouse_transmitter_if.sv | 29 ++
 rtl/ps2_clk_edge.sv | 19 +
 rtl/mouse_transmitter.sv | 194 +++++++++++++++++++
 tb/tb_mouse_transmitter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_ps2_pkg.sv
// Shared PS/2 definitions for the mouse transmitter/receiver pair: transmit state
// encoding, default cycle budgets, command bytes and small helpers.
package mouse_ps2_pkg;

    typedef logic [2:0] tx_state_t;
    typedef logic [7:0] ps2_byte_t;

    localparam tx_state_t ST_IDLE      = 3'd0;
    localparam tx_state_t ST_INHIBIT   = 3'd1;
    localparam tx_state_t ST_RTS       = 3'd2;
    localparam tx_state_t ST_DATA      = 3'd3;
    localparam tx_state_t ST_PARITY    = 3'd4;
    localparam tx_state_t ST_STOP      = 3'd5;
    localparam tx_state_t ST_ACK       = 3'd6;
    localparam tx_state_t ST_WAIT_IDLE = 3'd7;

    localparam int DEF_INHIBIT_CYCLES = 12000;
    localparam int DEF_RTS_CYCLES     = 20;
    localparam int DEF_TIMEOUT_CYCLES = 100000;

    localparam ps2_byte_t CMD_RESET  = 8'hFF;
    localparam ps2_byte_t CMD_ENABLE = 8'hF4;

    function automatic logic odd_parity(input ps2_byte_t b);
        return ~^b;
    endfunction

    // Width that holds the largest of the three cycle budgets.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mouse_transmitter_if.sv
// PS/2 line and byte-request bundle between the mouse master/device side (master)
// and the host transmitter (slave).
interface mouse_transmitter_if;
    import mouse_ps2_pkg::*;

    logic      CLK_MOUSE_IN;
    logic      CLK_MOUSE_OUT_EN;
    logic      DATA_MOUSE_IN;
    logic      DATA_MOUSE_OUT;
    logic      DATA_MOUSE_OUT_EN;
    logic      SEND_BYTE;
    ps2_byte_t BYTE_TO_SEND;
    logic      BYTE_SENT;
    logic      TX_BUSY;
    logic      TX_ERROR;

    modport master (
        output CLK_MOUSE_IN, DATA_MOUSE_IN, SEND_BYTE, BYTE_TO_SEND,
        input  CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN,
               BYTE_SENT, TX_BUSY, TX_ERROR
    );

    modport slave (
        input  CLK_MOUSE_IN, DATA_MOUSE_IN, SEND_BYTE, BYTE_TO_SEND,
        output CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN,
               BYTE_SENT, TX_BUSY, TX_ERROR
    );

endinterface

// File: rtl/ps2_clk_edge.sv
// PS/2 clock synchroniser and falling-edge detector, shared by the transmitter and
// receiver. The edge pulse combines the registered line with the live line.
module ps2_clk_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic clk_mouse_i,
    output logic fall_o
);

    logic clk_sync_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) clk_sync_q <= 1'b0;
        else       clk_sync_q <= clk_mouse_i;
    end

    assign fall_o = clk_sync_q & ~clk_mouse_i;

endmodule

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data bits LSB
// first, odd parity, stop, device ACK. Optional watchdog under MOUSE_TX_TIMEOUT_EN.
module mouse_transmitter
    import mouse_ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic               CLK,
    input logic               RESET,
    mouse_transmitter_if.slave bus
);

    // One width for every cycle counter so the watchdog can share the sizing.
    localparam int CNT_W = cnt_width(INHIBIT_CYCLES, RTS_CYCLES, TIMEOUT_CYCLES);

    logic fall;

    tx_state_t        curr_state,    next_state;
    ps2_byte_t        curr_shift,    next_shift;
    logic             curr_parity,   next_parity;
    logic [2:0]       curr_bit_ctr,  next_bit_ctr;
    logic [CNT_W-1:0] curr_cnt,      next_cnt;
    logic             curr_clk_en,   next_clk_en;
    logic             curr_data_en,  next_data_en;
    logic             curr_data_out, next_data_out;
    logic             curr_sent,     next_sent;
    logic             curr_error,    next_error;
`ifdef MOUSE_TX_TIMEOUT_EN
    logic [CNT_W-1:0] curr_timeout,  next_timeout;
`endif

    ps2_clk_edge u_clk_edge (
        .CLK         (CLK),
        .RESET       (RESET),
        .clk_mouse_i (bus.CLK_MOUSE_IN),
        .fall_o      (fall)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (RESET) begin
            curr_state    <= ST_IDLE;
            curr_shift    <= '0;
            curr_parity   <= 1'b0;
            curr_bit_ctr  <= '0;
            curr_cnt      <= '0;
            curr_clk_en   <= 1'b0;
            curr_data_en  <= 1'b0;
            curr_data_out <= 1'b0;
            curr_sent     <= 1'b0;
            curr_error    <= 1'b0;
`ifdef MOUSE_TX_TIMEOUT_EN
            curr_timeout  <= '0;
`endif
        end else begin
            curr_state    <= next_state;
            curr_shift    <= next_shift;
            curr_parity   <= next_parity;
            curr_bit_ctr  <= next_bit_ctr;
            curr_cnt      <= next_cnt;
            curr_clk_en   <= next_clk_en;
            curr_data_en  <= next_data_en;
            curr_data_out <= next_data_out;
            curr_sent     <= next_sent;
            curr_error    <= next_error;
`ifdef MOUSE_TX_TIMEOUT_EN
            curr_timeout  <= next_timeout;
`endif
        end
    end

    always_comb begin
        // NOTE: every next_* value is defaulted first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        next_state    = curr_state;
        next_shift    = curr_shift;
        next_parity   = curr_parity;
        next_bit_ctr  = curr_bit_ctr;
        next_cnt      = curr_cnt;
        next_clk_en   = curr_clk_en;
        next_data_en  = curr_data_en;
        next_data_out = curr_data_out;
        next_sent     = 1'b0;
        next_error    = 1'b0;

        case (curr_state)
            ST_IDLE: begin
                next_clk_en   = 1'b0;
                next_data_en  = 1'b0;
                next_data_out = 1'b0;
                if (bus.SEND_BYTE) begin
                    next_shift  = bus.BYTE_TO_SEND;
                    next_parity = odd_parity(bus.BYTE_TO_SEND);
                    next_cnt    = '0;
                    next_clk_en = 1'b1;
                    next_state  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (curr_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    next_cnt      = '0;
                    next_data_en  = 1'b1;
                    next_data_out = 1'b0;
                    next_state    = ST_RTS;
                end else begin
                    next_cnt = curr_cnt + CNT_W'(1);
                end
            end
            ST_RTS: begin
                if (curr_cnt == CNT_W'(RTS_CYCLES - 1)) begin
                    next_cnt     = '0;
                    next_clk_en  = 1'b0;
                    next_bit_ctr = '0;
                    next_state   = ST_DATA;
                end else begin
                    next_cnt = curr_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (fall) begin
                    next_data_out = curr_shift[0];
                    next_shift    = {1'b0, curr_shift[7:1]};
                    next_bit_ctr  = curr_bit_ctr + 3'd1;
                    if (curr_bit_ctr == 3'd7) next_state = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    next_data_out = curr_parity;
                    next_state    = ST_STOP;
                end
            end
            ST_STOP: begin
                // Stop bit is the released (pulled-up) line.
                if (fall) begin
                    next_data_en  = 1'b0;
                    next_data_out = 1'b0;
                    next_state    = ST_ACK;
                end
            end
            ST_ACK: begin
                if (fall) begin
                    if (!bus.DATA_MOUSE_IN) begin
                        next_state = ST_WAIT_IDLE;
                    end else begin
                        next_error = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (bus.CLK_MOUSE_IN && bus.DATA_MOUSE_IN) begin
                    next_sent  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state    = ST_IDLE;
                next_clk_en   = 1'b0;
                next_data_en  = 1'b0;
                next_data_out = 1'b0;
            end
        endcase

`ifdef MOUSE_TX_TIMEOUT_EN
        // Watchdog on the gap between device clock edges; cleared outside the
        // device-clocked states and on every falling edge.
        next_timeout = '0;
        if ((curr_state inside {ST_DATA, ST_PARITY, ST_STOP, ST_ACK}) && !fall) begin
            if (curr_timeout == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                next_state    = ST_IDLE;
                next_clk_en   = 1'b0;
                next_data_en  = 1'b0;
                next_data_out = 1'b0;
                next_sent     = 1'b0;
                next_error    = 1'b1;
            end else begin
                next_timeout = curr_timeout + CNT_W'(1);
            end
        end
`endif
    end

    assign bus.CLK_MOUSE_OUT_EN  = curr_clk_en;
    assign bus.DATA_MOUSE_OUT_EN = curr_data_en;
    assign bus.DATA_MOUSE_OUT    = curr_data_out;
    assign bus.BYTE_SENT         = curr_sent;
    assign bus.TX_ERROR          = curr_error;
    assign bus.TX_BUSY           = (curr_state != ST_IDLE);

endmodule

// File: tb/tb_mouse_transmitter.sv
// Scoreboard bench for mouse_transmitter: a behavioural PS/2 device clocks frames,
// a monitor compares each BYTE_SENT/TX_ERROR pulse against queued expectations.
module tb_mouse_transmitter;
    import mouse_ps2_pkg::*;

    localparam int INHIBIT_P = 1200;
    localparam int RTS_P     = 20;
    localparam int TIMEOUT_P = 5000;
    localparam int HALF      = 8;
    localparam int XFER_BUDGET = INHIBIT_P + RTS_P + 24 * HALF + 400;

    typedef struct { logic [7:0] data; logic err; logic frame; } exp_t;
    typedef struct { logic ack_bit; int stop_after; } dev_cmd_t;
    typedef struct { logic [7:0] data; logic par; logic stop; } obs_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    exp_t     exp_q[$];
    dev_cmd_t dev_q[$];
    obs_t     obs_q[$];

    int checks = 0;
    int errors = 0;
    int dev_edges = 0;
    bit dev_busy = 1'b0;
    int low_cnt = 0;
    bit data_seen = 1'b0;

    mouse_transmitter_if bus();

    // Open-drain wired-AND of host and device drivers with pull-ups.
    assign bus.CLK_MOUSE_IN  = dev_clk & ~bus.CLK_MOUSE_OUT_EN;
    assign bus.DATA_MOUSE_IN = dev_data & (bus.DATA_MOUSE_OUT_EN ? bus.DATA_MOUSE_OUT : 1'b1);

    mouse_transmitter #(
        .INHIBIT_CYCLES (INHIBIT_P),
        .RTS_CYCLES     (RTS_P),
        .TIMEOUT_CYCLES (TIMEOUT_P)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Device side: generates clocks, samples host data on rising edges, ACKs.
    task automatic dev_frame(input dev_cmd_t c);
        logic [9:0] bits;
        obs_t o;
        bits = '0;
        repeat (HALF) @(negedge CLK);
        for (int e = 1; e <= 11 && e <= c.stop_after; e++) begin
            if (e == 11) dev_data = c.ack_bit;
            dev_clk = 1'b0;
            dev_edges++;
            repeat (HALF) @(negedge CLK);
            if (e <= 10) bits[e-1] = bus.DATA_MOUSE_IN;
            dev_clk = 1'b1;
            if (e == 10) begin
                o.data = bits[7:0];
                o.par  = bits[8];
                o.stop = bits[9];
                obs_q.push_back(o);
            end
            repeat (HALF) @(negedge CLK);
        end
        dev_data = 1'b1;
    endtask

    initial begin : device
        dev_cmd_t c;
        forever begin
            @(negedge CLK);
            if (dev_q.size() > 0 && !RESET && bus.TX_BUSY && !bus.CLK_MOUSE_OUT_EN &&
                bus.DATA_MOUSE_OUT_EN && !bus.DATA_MOUSE_OUT) begin
                c = dev_q.pop_front();
                dev_busy = 1'b1;
                dev_frame(c);
                dev_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        obs_t o;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                low_cnt   = 0;
                data_seen = 1'b0;
            end else begin
                if (bus.CLK_MOUSE_OUT_EN) begin
                    if (bus.DATA_MOUSE_OUT_EN && !data_seen) begin
                        data_seen = 1'b1;
                        check("data_held_off_during_inhibit", int'(low_cnt >= INHIBIT_P), 1);
                    end
                    low_cnt++;
                end else if (low_cnt > 0) begin
                    check("clk_low_cycles", low_cnt, INHIBIT_P + RTS_P);
                    check("start_bit_at_clk_release",
                          int'({bus.DATA_MOUSE_OUT_EN, bus.DATA_MOUSE_OUT}), 2);
                    check("busy_at_clk_release", int'(bus.TX_BUSY), 1);
                    low_cnt   = 0;
                    data_seen = 1'b0;
                end

                if (bus.BYTE_SENT || bus.TX_ERROR) begin
                    check("pulses_exclusive", int'(bus.BYTE_SENT & bus.TX_ERROR), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", int'({bus.TX_ERROR, bus.BYTE_SENT}), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("outcome_is_error", int'(bus.TX_ERROR), int'(e.err));
                        check("idle_at_pulse", int'(bus.TX_BUSY), 0);
                        check("lines_released_at_pulse",
                              int'({bus.CLK_MOUSE_OUT_EN, bus.DATA_MOUSE_OUT_EN}), 0);
                        if (e.frame) begin
                            check("frame_captured", int'(obs_q.size() > 0), 1);
                            if (obs_q.size() > 0) begin
                                o = obs_q.pop_front();
                                check("data_bits", int'(o.data), int'(e.data));
                                check("parity_bit", int'(o.par),
                                      int'(($countones(e.data) % 2) == 0));
                                check("stop_bit", int'(o.stop), 1);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.TX_BUSY || dev_busy || dev_q.size() > 0) && n < XFER_BUDGET) begin
            @(negedge CLK);
            n++;
        end
        if (n >= XFER_BUDGET) check("transaction_done_in_budget", int'(bus.TX_BUSY), 0);
        repeat (4) @(negedge CLK);
    endtask

    task automatic wait_edges(input int target);
        int n;
        n = 0;
        while (dev_edges < target && n < XFER_BUDGET) begin
            @(negedge CLK);
            n++;
        end
        if (n >= XFER_BUDGET) check("device_edges_reached", dev_edges, target);
    endtask

    task automatic accept(input logic [7:0] b);
        @(negedge CLK);
        bus.SEND_BYTE    = 1'b1;
        bus.BYTE_TO_SEND = b;
        @(negedge CLK);
        bus.SEND_BYTE    = 1'b0;
        bus.BYTE_TO_SEND = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] b, input logic nack, input bit interfere);
        dev_cmd_t c;
        exp_t e;
        int start;
        c.ack_bit = nack;
        c.stop_after = 11;
        e.data = b;
        e.err = nack;
        e.frame = 1'b1;
        start = dev_edges;
        dev_q.push_back(c);
        exp_q.push_back(e);
        accept(b);
        if (interfere) begin
            wait_edges(start + 3);
            accept(8'hAA);
        end
        wait_idle();
    endtask

    initial begin : stimulus
        dev_cmd_t c;
        exp_t e;
        int start;
        int n;
        bus.SEND_BYTE    = 1'b0;
        bus.BYTE_TO_SEND = 8'h00;

        repeat (3) @(negedge CLK);
        check("reset_line_enables", int'({bus.CLK_MOUSE_OUT_EN, bus.DATA_MOUSE_OUT_EN}), 0);
        check("reset_data_out", int'(bus.DATA_MOUSE_OUT), 0);
        check("reset_pulses", int'({bus.BYTE_SENT, bus.TX_ERROR}), 0);
        check("reset_busy", int'(bus.TX_BUSY), 0);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);

        send(CMD_ENABLE, 1'b0, 1'b0);
        send(CMD_RESET,  1'b0, 1'b0);
        send(8'h3C,      1'b1, 1'b0);
        send(8'h5A,      1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
        end

        // Reset during the data phase, after the 4th device edge.
        c.ack_bit = 1'b0;
        c.stop_after = 4;
        start = dev_edges;
        dev_q.push_back(c);
        accept(8'hC3);
        wait_edges(start + 4);
        repeat (2) @(negedge CLK);
        check("data_driven_before_reset", int'(bus.DATA_MOUSE_OUT_EN), 1);
        RESET = 1'b1;
        #1;
        check("lines_released_on_reset", int'({bus.CLK_MOUSE_OUT_EN, bus.DATA_MOUSE_OUT_EN}), 0);
        check("idle_on_reset", int'(bus.TX_BUSY), 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        wait_idle();
        send(8'h00, 1'b0, 1'b0);

        // Device stops clocking after 5 edges.
        c.ack_bit = 1'b0;
        c.stop_after = 5;
        start = dev_edges;
        dev_q.push_back(c);
`ifdef MOUSE_TX_TIMEOUT_EN
        e.data = 8'h96;
        e.err = 1'b1;
        e.frame = 1'b0;
        exp_q.push_back(e);
`endif
        accept(8'h96);
        wait_edges(start + 5);
`ifdef MOUSE_TX_TIMEOUT_EN
        n = 0;
        while (bus.TX_BUSY && n < TIMEOUT_P + 200) begin
            @(negedge CLK);
            n++;
        end
        check("timeout_latency_in_window", int'(n >= TIMEOUT_P && n <= TIMEOUT_P + 4), 1);
        wait_idle();
`else
        n = 0;
        repeat (2 * TIMEOUT_P) @(negedge CLK);
        check("still_busy_without_timeout", int'(bus.TX_BUSY), 1);
        check("no_release_without_timeout", int'(bus.DATA_MOUSE_OUT_EN), 1);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        wait_idle();
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        check("frames_drained", obs_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
